// File: rtl/rca_seq_adder_64_if.sv
// rtl/rca_seq_adder_64_if.sv - operand/result handshake bundle for the sequential 64-bit adder
interface rca_seq_adder_64_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_seq_adder_64.sv
// rtl/rca_seq_adder_64.sv - 64-bit add/sub time-sharing one 16-bit ripple adder over four cycles
module rca_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [16:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[16];
endmodule

module rca_seq_adder_64 (
    input  logic                clk,
    input  logic                rst_n,
    rca_seq_adder_64_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  slice_cnt_q, slice_cnt_d;
    logic        carry_q, carry_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        c0_q, c0_d;
    logic [63:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;

    logic [15:0] slice_a, slice_b, slice_s;
    logic        slice_cin, slice_cout;

    // b is stored already inverted for subtraction so the datapath only ever adds
    always_comb begin
        slice_a   = a_q[{slice_cnt_q, 4'b0000} +: 16];
        slice_b   = b_q[{slice_cnt_q, 4'b0000} +: 16];
        slice_cin = (slice_cnt_q == 2'd0) ? c0_q : carry_q;
    end

    rca_16bits u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        slice_cnt_d = slice_cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        c0_d        = c0_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d         = bus.a;
                    b_d         = bus.sub ? ~bus.b : bus.b;
                    c0_d        = bus.sub | bus.cin;
                    slice_cnt_d = 2'd0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                sum_d[{slice_cnt_q, 4'b0000} +: 16] = slice_s;
                carry_d = slice_cout;
                if (slice_cnt_q == 2'd3) begin
                    cout_d      = slice_cout;
                    // carry into bit 63 recovered from the sum bit, xor carry out of it
                    ovf_d       = a_q[63] ^ b_q[63] ^ slice_s[15] ^ slice_cout;
                    slice_cnt_d = 2'd0;
                    state_d     = DONE;
                end else begin
                    slice_cnt_d = slice_cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slice_cnt_q <= 2'd0;
            carry_q     <= 1'b0;
            a_q         <= 64'd0;
            b_q         <= 64'd0;
            c0_q        <= 1'b0;
            sum_q       <= 64'd0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slice_cnt_q <= slice_cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c0_q        <= c0_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
